// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction, issues BIU request pulses and brackets the EU for ALU ops.
// Defining INSTR_SEQ_WDT_EN adds a per-wait-state watchdog that halts with err on timeout.
module instr_sequencer #(
   parameter int IR_W    = 32,
   parameter int TMO_CYC = 64,
   parameter int TMO_W   = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [IR_W-1:0] instr,
   output logic            instr_ready,
   output logic            cs,
   output logic [1:0]      sel,
   output logic [1:0]      sel_eu,
   output logic [1:0]      op_sel,
   output logic [IR_W-1:0] ir,
   input  logic            biu_ready,
   output logic            eu_start,
   input  logic            eu_done,
   output logic            busy,
   output logic            halted,
   output logic            err
);

   localparam logic [1:0] SEL_ALU   = 2'b10;
   localparam logic [1:0] OP_A      = 2'b00;
   localparam logic [1:0] OP_B      = 2'b01;
   localparam logic [1:0] OP_WR     = 2'b10;
   localparam logic [1:0] EU_SINGLE = 2'b00;
   localparam logic [1:0] EU_CMP    = 2'b10;
   localparam logic [1:0] EU_BAD    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_EU_START,
      S_EU_WAIT,
      S_HALT
   } state_e;

   state_e          state_q, state_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      sel_eu_q, sel_eu_d;
   logic [1:0]      op_sel_q, op_sel_d;
   logic            err_q, err_d;

`ifdef INSTR_SEQ_WDT_EN
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Next-state logic: decode on acceptance, then walk ISSUE/WAIT_ACK/WAIT_DONE and the EU bracket
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      sel_d    = sel_q;
      sel_eu_d = sel_eu_q;
      op_sel_d = op_sel_q;
      err_d    = err_q;
`ifdef INSTR_SEQ_WDT_EN
      tmo_d    = '0;
`endif

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               ir_d = instr;
               case (instr[21:20])
                  2'b00, 2'b01: begin
                     sel_d    = instr[21:20];
                     op_sel_d = OP_A;
                     state_d  = S_ISSUE;
                  end
                  2'b10: begin
                     sel_d    = SEL_ALU;
                     sel_eu_d = instr[23:22];
                     op_sel_d = OP_A;
                     if (instr[23:22] == EU_BAD) begin
                        err_d = 1'b1;
                     end else begin
                        state_d = S_ISSUE;
                     end
                  end
                  default: state_d = S_HALT;
               endcase
            end
         end
         S_ISSUE: state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!biu_ready) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (biu_ready) begin
               if (sel_q != SEL_ALU) begin
                  state_d = S_IDLE;
               end else begin
                  case (op_sel_q)
                     OP_A: begin
                        if (sel_eu_q == EU_SINGLE) begin
                           state_d = S_EU_START;
                        end else begin
                           op_sel_d = OP_B;
                           state_d  = S_ISSUE;
                        end
                     end
                     OP_B:    state_d = S_EU_START;
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end
         S_EU_START: state_d = S_EU_WAIT;
         S_EU_WAIT: begin
            if (eu_done) begin
               if (sel_eu_q == EU_CMP) begin
                  state_d = S_IDLE;
               end else begin
                  op_sel_d = OP_WR;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

`ifdef INSTR_SEQ_WDT_EN
      if ((state_d == state_q) &&
          ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE) || (state_q == S_EU_WAIT))) begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_d == TMO_W'(TMO_CYC)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
         end
      end
`endif
   end

   // State and instruction registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ir_q     <= '0;
         sel_q    <= 2'b00;
         sel_eu_q <= 2'b00;
         op_sel_q <= 2'b00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         sel_q    <= sel_d;
         sel_eu_q <= sel_eu_d;
         op_sel_q <= op_sel_d;
         err_q    <= err_d;
      end
   end

`ifdef INSTR_SEQ_WDT_EN
   // Watchdog counter register, restarted on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign instr_ready = (state_q == S_IDLE);
   assign cs          = (state_q == S_ISSUE);
   assign eu_start    = (state_q == S_EU_START);
   assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted      = (state_q == S_HALT);
   assign err         = err_q;
   assign ir          = ir_q;
   assign sel         = sel_q;
   assign sel_eu      = sel_eu_q;
   assign op_sel      = op_sel_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected BIU/EU events are queued at issue and checked as they occur.
// Define INSTR_SEQ_WDT_EN to build the DUT with TMO_CYC = 8 and run the watchdog scenario.
module tb_instr_sequencer;

`ifdef INSTR_SEQ_WDT_EN
   localparam int TbTmoCyc = 8;
   localparam int TbTmoW   = 4;
`else
   localparam int TbTmoCyc = 64;
   localparam int TbTmoW   = 7;
`endif

   typedef struct packed {
      logic        isEu;
      logic        chkSelEu;
      logic [1:0]  sel;
      logic [1:0]  selEu;
      logic [1:0]  opSel;
      logic [31:0] ir;
   } expEvt_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        instr_ready;
   logic        cs;
   logic [1:0]  sel;
   logic [1:0]  sel_eu;
   logic [1:0]  op_sel;
   logic [31:0] ir;
   logic        biu_ready;
   logic        eu_start;
   logic        eu_done;
   logic        busy;
   logic        halted;
   logic        err;

   expEvt_t expQ[$];
   expEvt_t monEvt;
   int      totalChecks = 0;
   int      badChecks = 0;
   int      csCount = 0;
   int      biuMode = 0;
   int      euMode = 0;
   int      biuPhase = 0;
   int      lowCnt = 0;
   int      euPhase = 0;
   int      lat;
   int      csBefore;

   always #5 clk = ~clk;

   instr_sequencer #(.IR_W(32), .TMO_CYC(TbTmoCyc), .TMO_W(TbTmoW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .cs          (cs),
      .sel         (sel),
      .sel_eu      (sel_eu),
      .op_sel      (op_sel),
      .ir          (ir),
      .biu_ready   (biu_ready),
      .eu_start    (eu_start),
      .eu_done     (eu_done),
      .busy        (busy),
      .halted      (halted),
      .err         (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      totalChecks++;
      if (got !== want) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic expEvt_t mkEvt(input logic isEu, input logic chk, input logic [1:0] s,
                                     input logic [1:0] se, input logic [1:0] op, input logic [31:0] w);
      expEvt_t e;
      e.isEu = isEu; e.chkSelEu = chk; e.sel = s; e.selEu = se; e.opSel = op; e.ir = w;
      return e;
   endfunction

   // Reference model: expected request/EU sequence for one instruction word
   task automatic pushExpected(input logic [31:0] w);
      logic [1:0] cls;
      logic [1:0] sub;
      cls = w[21:20];
      sub = w[23:22];
      if (cls == 2'b00 || cls == 2'b01) begin
         expQ.push_back(mkEvt(1'b0, 1'b0, cls, 2'b00, 2'b00, w));
      end else if (cls == 2'b10 && sub != 2'b11) begin
         expQ.push_back(mkEvt(1'b0, 1'b1, 2'b10, sub, 2'b00, w));
         if (sub != 2'b00) expQ.push_back(mkEvt(1'b0, 1'b1, 2'b10, sub, 2'b01, w));
         expQ.push_back(mkEvt(1'b1, 1'b0, 2'b10, sub, 2'b00, w));
         if (sub != 2'b10) expQ.push_back(mkEvt(1'b0, 1'b1, 2'b10, sub, 2'b10, w));
      end
   endtask

   // Offers w at a negedge, waits for acceptance, optionally keeps instr_valid high afterwards
   task automatic applyStimulus(input logic [31:0] w, input bit hold);
      int n;
      instr = w;
      instr_valid = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (instr_ready !== 1'b1) checkOutput("accept_timeout", {31'b0, instr_ready}, 32'd1);
      pushExpected(w);
      @(posedge clk);
      #1;
      if (!hold) instr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic waitIdle(input string tag, output int cycles);
      cycles = 1;
      while (instr_ready !== 1'b1 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      if (instr_ready !== 1'b1) checkOutput({tag, "_idle_timeout"}, {31'b0, instr_ready}, 32'd1);
      checkOutput({tag, "_queue_empty"}, expQ.size(), 32'd0);
   endtask

   // BIU responder: 0 = drop 1 cycle after cs for 3 cycles, 1 = ready already low at cs, 2 = never acks
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         biu_ready = 1'b1;
         biuPhase = 0;
      end else if (biuMode == 2) begin
         biu_ready = 1'b1;
         biuPhase = 0;
      end else begin
         case (biuPhase)
            0: begin
               biu_ready = (biuMode == 1) ? 1'b0 : 1'b1;
               if (cs === 1'b1) begin
                  biuPhase = (biuMode == 1) ? 2 : 1;
                  lowCnt = 1;
               end
            end
            1: begin
               biu_ready = 1'b0;
               biuPhase = 2;
               lowCnt = 1;
            end
            default: begin
               if (lowCnt == 3) begin
                  biu_ready = 1'b1;
                  biuPhase = 0;
               end else begin
                  lowCnt++;
               end
            end
         endcase
      end
   end

   // EU responder: 0 = eu_done 2 cycles after eu_start, 1 = never done, 2 = stray eu_done held high
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         eu_done = 1'b0;
         euPhase = 0;
      end else if (euMode == 2) begin
         eu_done = 1'b1;
      end else if (euMode == 1) begin
         eu_done = 1'b0;
         euPhase = 0;
      end else begin
         case (euPhase)
            0: begin
               eu_done = 1'b0;
               if (eu_start === 1'b1) euPhase = 1;
            end
            1: euPhase = 2;
            2: begin
               eu_done = 1'b1;
               euPhase = 3;
            end
            default: begin
               eu_done = 1'b0;
               euPhase = 0;
            end
         endcase
      end
   end

   // Scoreboard monitor: every cs or eu_start pulse must match the head of the queue
   initial forever begin
      @(negedge clk);
      if (cs === 1'b1) begin
         csCount++;
         if (expQ.size() == 0) begin
            checkOutput("sb_cs_unexpected", expQ.size(), 32'd1);
         end else begin
            monEvt = expQ.pop_front();
            checkOutput("sb_cs_kind", {31'b0, eu_start}, {31'b0, monEvt.isEu});
            checkOutput("sb_sel", {30'b0, sel}, {30'b0, monEvt.sel});
            if (monEvt.chkSelEu) checkOutput("sb_sel_eu", {30'b0, sel_eu}, {30'b0, monEvt.selEu});
            checkOutput("sb_op_sel", {30'b0, op_sel}, {30'b0, monEvt.opSel});
            checkOutput("sb_ir", ir, monEvt.ir);
         end
      end
      if (eu_start === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("sb_eu_unexpected", expQ.size(), 32'd1);
         end else begin
            monEvt = expQ.pop_front();
            checkOutput("sb_eu_kind", {31'b0, eu_start}, {31'b0, monEvt.isEu});
            checkOutput("sb_eu_ir", ir, monEvt.ir);
         end
      end
   end

   // Global time limit
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got=running want=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Main test sequence
   initial begin
      $display("[TB] starting instr_sequencer bench");
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
      checkOutput("rst_cs", {31'b0, cs}, 32'd0);
      checkOutput("rst_eu_start", {31'b0, eu_start}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_halted", {31'b0, halted}, 32'd0);
      checkOutput("rst_err", {31'b0, err}, 32'd0);
      checkOutput("rst_ir", ir, 32'd0);
      checkOutput("rst_sels", {26'b0, sel, sel_eu, op_sel}, 32'd0);

      // Register move with the standard BIU timing
      csBefore = csCount;
      applyStimulus(32'h0008_A001, 1'b0);
      waitIdle("move", lat);
      checkOutput("move_latency", lat, 32'd6);
      checkOutput("move_cs_pulses", csCount - csBefore, 32'd1);
      checkOutput("move_busy", {31'b0, busy}, 32'd0);
      checkOutput("move_ir", ir, 32'h0008_A001);
      checkOutput("move_sel", {30'b0, sel}, 32'd0);

      // Move where biu_ready is already low during the cs pulse
      @(posedge clk);
      biuMode = 1;
      @(negedge clk);
      csBefore = csCount;
      applyStimulus(32'h0000_BEEF, 1'b0);
      waitIdle("early", lat);
      checkOutput("early_latency", lat, 32'd5);
      checkOutput("early_cs_pulses", csCount - csBefore, 32'd1);
      @(posedge clk);
      biuMode = 0;
      @(negedge clk);
      @(negedge clk);

      // ALU two-operand op, then compare (no write step)
      csBefore = csCount;
      applyStimulus(32'h0060_1234, 1'b0);
      waitIdle("alu01", lat);
      checkOutput("alu01_cs_pulses", csCount - csBefore, 32'd3);
      csBefore = csCount;
      applyStimulus(32'h00A0_5678, 1'b0);
      waitIdle("alu10", lat);
      checkOutput("alu10_cs_pulses", csCount - csBefore, 32'd2);
      checkOutput("alu10_sel_eu", {30'b0, sel_eu}, 32'd2);

      // Back-to-back memory transfers with instr_valid held high
      applyStimulus(32'h0010_1111, 1'b1);
      instr = 32'h0010_2222;
      for (int i = 0; i < 3; i++) begin
         checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
         checkOutput("b2b_ir_stable", ir, 32'h0010_1111);
         @(negedge clk);
      end
      applyStimulus(32'h0010_2222, 1'b0);
      waitIdle("b2b", lat);
      checkOutput("b2b_ir_second", ir, 32'h0010_2222);

      // Stray eu_done while idle must not start anything
      @(posedge clk);
      euMode = 2;
      @(negedge clk);
      @(posedge clk);
      euMode = 0;
      @(negedge clk);
      checkOutput("stray_eu_busy", {31'b0, busy}, 32'd0);
      checkOutput("stray_eu_ready", {31'b0, instr_ready}, 32'd1);

      // Asynchronous reset while waiting for the EU
      @(posedge clk);
      euMode = 1;
      @(negedge clk);
      applyStimulus(32'h0020_0F0F, 1'b0);
      lat = 0;
      while (eu_start !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("rst_mid_eu_start_seen", {31'b0, eu_start}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mid_pre_busy", {31'b0, busy}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_cs", {31'b0, cs}, 32'd0);
      checkOutput("rst_mid_eu_start", {31'b0, eu_start}, 32'd0);
      checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
      expQ.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      euMode = 0;
      @(negedge clk);
      checkOutput("rst_mid_instr_ready", {31'b0, instr_ready}, 32'd1);
      checkOutput("rst_mid_ir", ir, 32'd0);

      // Illegal ALU sub-class: sticky err, no BIU traffic
      csBefore = csCount;
      applyStimulus(32'h00E0_00AA, 1'b0);
      checkOutput("illegal_err", {31'b0, err}, 32'd1);
      checkOutput("illegal_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("illegal_no_cs", csCount - csBefore, 32'd0);
      checkOutput("illegal_err_sticky", {31'b0, err}, 32'd1);

      // HALT is absorbing
      applyStimulus(32'h0030_0000, 1'b0);
      checkOutput("halt_halted", {31'b0, halted}, 32'd1);
      checkOutput("halt_ready", {31'b0, instr_ready}, 32'd0);
      csBefore = csCount;
      instr = 32'h0008_A001;
      instr_valid = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("halt_still_ready", {31'b0, instr_ready}, 32'd0);
      checkOutput("halt_still_halted", {31'b0, halted}, 32'd1);
      checkOutput("halt_no_cs", csCount - csBefore, 32'd0);
      instr_valid = 1'b0;

`ifdef INSTR_SEQ_WDT_EN
      // Watchdog: BIU never acknowledges the request
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      biuMode = 2;
      @(negedge clk);
      applyStimulus(32'h0008_A001, 1'b0);
      lat = 1;
      while (halted !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("wdt_latency", lat, 32'd10);
      checkOutput("wdt_err", {31'b0, err}, 32'd1);
      checkOutput("wdt_halted", {31'b0, halted}, 32'd1);
      checkOutput("wdt_cs", {31'b0, cs}, 32'd0);
      checkOutput("wdt_queue_empty", expQ.size(), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
